// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - SPI APB sequencer register map, SR bit indices and state encodings
package spi_seq_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  localparam int SR_SPIF  = 7;
  localparam int SR_SPTEF = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG_CR1,
    S_CFG_CR2,
    S_CFG_BR,
    S_WR_DR,
    S_POLL_TX,
    S_POLL_RX,
    S_RD_DR,
    S_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_ACCESS,
    X_GAP
  } xact_state_e;

endpackage

// File: rtl/spi_apb_xact.sv
// rtl/spi_apb_xact.sv - single APB access engine: SETUP, ACCESS until PREADY, one idle gap
module spi_apb_xact
  import spi_seq_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       start,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [2:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  xact_state_e x_state, x_next;
  logic [2:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;

  // state register
  always_ff @(posedge PCLK) begin
    if (PRESET) x_state <= X_IDLE;
    else        x_state <= x_next;
  end

  // SETUP is the idle cycle in which start is seen, so each access costs setup + access + gap
  always_comb begin
    x_next = x_state;
    case (x_state)
      X_IDLE:   if (start)  x_next = X_ACCESS;
      X_ACCESS: if (PREADY) x_next = X_GAP;
      X_GAP:    x_next = X_IDLE;
      default:  x_next = X_IDLE;
    endcase
  end

  // hold the access fields through ACCESS and capture the completion response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata   <= '0;
      slverr  <= 1'b0;
    end else begin
      if (x_state == X_IDLE && start) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= write;
      end
      if (x_state == X_ACCESS && PREADY) begin
        rdata  <= PRDATA;
        slverr <= PSLVERR;
      end
    end
  end

  // bus drive; done is reported in the gap cycle once rdata/slverr are registered
  always_comb begin
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    done    = 1'b0;
    case (x_state)
      X_IDLE: begin
        if (start) begin
          PSEL   = 1'b1;
          PWRITE = write;
          PADDR  = addr;
          PWDATA = wdata;
        end
      end
      X_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = write_q;
        PADDR   = addr_q;
        PWDATA  = wdata_q;
      end
      X_GAP:   done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule

// File: rtl/spi_apb_sequencer.sv
// rtl/spi_apb_sequencer.sv - round-robin byte sequencer over the SPI APB slave; SEQ_TIMEOUT_EN bounds SR polling
module spi_apb_sequencer
  import spi_seq_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int POLL_LIMIT = 1023,
  parameter int CNT_W      = 10
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [7:0]           cfg_cr1,
  input  logic [7:0]           cfg_cr2,
  input  logic [7:0]           cfg_br,
  input  logic                 cfg_load,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rx_data,
  output logic                 err,
  output logic                 busy,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [2:0]           PADDR,
  output logic [7:0]           PWDATA,
  input  logic [7:0]           PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  if (CNT_W < $clog2(POLL_LIMIT + 1)) begin : g_cnt_w_check
    $error("CNT_W cannot hold POLL_LIMIT");
  end

  seq_state_e state, state_next;
  logic       cfg_pending;
  logic [7:0] cr1_q, cr2_q, br_q, tx_q, rx_q;
  logic [1:0] ptr, gnt, pick;
  logic       any_req, err_acc, enter_cfg, grant, poll_bit, timeout_hit;
  logic       x_start, x_write, x_done, x_slverr;
  logic [2:0] x_addr;
  logic [7:0] x_wdata, x_rdata;

  assign enter_cfg = (state == S_IDLE) && cfg_pending;
  assign grant     = (state == S_IDLE) && !cfg_pending && any_req;
  assign poll_bit  = (state == S_POLL_TX) ? x_rdata[SR_SPTEF] : x_rdata[SR_SPIF];

  // first requesting index at or after the pointer; descending scan leaves the nearest one
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        pick    = 2'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] poll_cnt;

  assign timeout_hit = (state == S_POLL_TX || state == S_POLL_RX) && x_done && !poll_bit &&
                       (poll_cnt == CNT_W'(POLL_LIMIT - 1));

  // saturating SR read counter, restarted on each poll-phase entry
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      poll_cnt <= '0;
    end else if ((state_next == S_POLL_TX || state_next == S_POLL_RX) && state_next != state) begin
      poll_cnt <= '0;
    end else if ((state == S_POLL_TX || state == S_POLL_RX) && x_done && !(&poll_cnt)) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // sequencing: config first when pending, otherwise one byte per grant
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (cfg_pending) state_next = S_CFG_CR1;
                 else if (any_req) state_next = S_WR_DR;
      S_CFG_CR1: if (x_done) state_next = S_CFG_CR2;
      S_CFG_CR2: if (x_done) state_next = S_CFG_BR;
      S_CFG_BR:  if (x_done) state_next = S_IDLE;
      S_WR_DR:   if (x_done) state_next = S_POLL_TX;
      S_POLL_TX: if (x_done && poll_bit) state_next = S_POLL_RX;
                 else if (timeout_hit) state_next = S_DONE;
      S_POLL_RX: if (x_done && poll_bit) state_next = S_RD_DR;
                 else if (timeout_hit) state_next = S_DONE;
      S_RD_DR:   if (x_done) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // per-state access request and client-side outputs
  always_comb begin
    x_start = 1'b0;
    x_write = 1'b0;
    x_addr  = ADDR_CR1;
    x_wdata = '0;
    done    = '0;
    rx_data = '0;
    err     = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_CFG_CR1: begin x_start = 1'b1; x_write = 1'b1; x_addr = ADDR_CR1; x_wdata = cr1_q; end
      S_CFG_CR2: begin x_start = 1'b1; x_write = 1'b1; x_addr = ADDR_CR2; x_wdata = cr2_q; end
      S_CFG_BR:  begin x_start = 1'b1; x_write = 1'b1; x_addr = ADDR_BR;  x_wdata = br_q;  end
      S_WR_DR:   begin x_start = 1'b1; x_write = 1'b1; x_addr = ADDR_DR;  x_wdata = tx_q;  end
      S_POLL_TX, S_POLL_RX: begin x_start = 1'b1; x_addr = ADDR_SR; end
      S_RD_DR:   begin x_start = 1'b1; x_addr = ADDR_DR; end
      S_DONE: begin
        done    = NUM_REQ'(1) << gnt;
        rx_data = rx_q;
        err     = err_acc;
      end
      default: x_start = 1'b0;
    endcase
  end

  // config/grant latches, sticky error (config errors ride on the next done), rx byte, pointer
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cfg_pending <= 1'b1;
      cr1_q       <= '0;
      cr2_q       <= '0;
      br_q        <= '0;
      ptr         <= '0;
      gnt         <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      err_acc     <= 1'b0;
    end else begin
      cfg_pending <= cfg_load | (cfg_pending & ~enter_cfg);
      if (enter_cfg) begin
        cr1_q <= cfg_cr1;
        cr2_q <= cfg_cr2;
        br_q  <= cfg_br;
      end
      if (grant) begin
        gnt  <= pick;
        tx_q <= req_data[8*int'(pick) +: 8];
      end
      if (state == S_DONE) begin
        err_acc <= 1'b0;
        ptr     <= (gnt == 2'(NUM_REQ - 1)) ? 2'd0 : gnt + 2'd1;
      end
      if ((x_done && x_slverr) || timeout_hit) err_acc <= 1'b1;
      if (state == S_RD_DR && x_done) rx_q <= x_rdata;
      if (timeout_hit) rx_q <= '0;
    end
  end

  spi_apb_xact u_xact (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .start   (x_start),
    .addr    (x_addr),
    .wdata   (x_wdata),
    .write   (x_write),
    .done    (x_done),
    .rdata   (x_rdata),
    .slverr  (x_slverr),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

endmodule

// File: tb/tb_spi_apb_sequencer.sv
// tb/tb_spi_apb_sequencer.sv - scoreboard bench for spi_apb_sequencer with an APB slave model
module tb_spi_apb_sequencer;

  localparam int NR = 2;
`ifdef SEQ_TIMEOUT_EN
  localparam int PL = 4;
`else
  localparam int PL = 1023;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [7:0]    cfg_cr1, cfg_cr2, cfg_br;
  logic          cfg_load;
  logic [NR-1:0] req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] done;
  logic [7:0]    rx_data;
  logic          err, busy, PSEL, PENABLE, PWRITE;
  logic [2:0]    PADDR;
  logic [7:0]    PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  initial forever #5 PCLK = ~PCLK;

  spi_apb_sequencer #(.NUM_REQ(NR), .POLL_LIMIT(PL), .CNT_W(10)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cfg_cr1(cfg_cr1), .cfg_cr2(cfg_cr2), .cfg_br(cfg_br),
    .cfg_load(cfg_load), .req(req), .req_data(req_data), .done(done), .rx_data(rx_data),
    .err(err), .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct { logic w; logic [2:0] a; logic [7:0] d; } acc_t;
  typedef struct { int stall; logic [7:0] rd; logic se; } rsp_t;
  typedef struct { int idx; logic [7:0] rx; logic er; } dn_t;

  acc_t exp_acc[$];
  rsp_t rsp_q[$];
  dn_t  exp_dn[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_acc(input logic w, input logic [2:0] a, input logic [7:0] d,
                          input int stall, input logic [7:0] rd, input logic se);
    acc_t t;
    rsp_t r;
    t.w = w; t.a = a; t.d = d;
    r.stall = stall; r.rd = rd; r.se = se;
    exp_acc.push_back(t);
    rsp_q.push_back(r);
  endtask

  task automatic push_done(input int idx, input logic [7:0] rx, input logic er);
    dn_t t;
    t.idx = idx; t.rx = rx; t.er = er;
    exp_dn.push_back(t);
  endtask

  // DR write, SR=0x20 (sptef), SR=0x80 (spif), DR read
  task automatic push_xfer(input logic [7:0] tx, input logic [7:0] rx, input int idx,
                           input logic sr_err, input int wr_stall, input logic er);
    push_acc(1'b1, 3'd5, tx, wr_stall, 8'h00, 1'b0);
    push_acc(1'b0, 3'd3, 8'h00, 0, 8'h20, sr_err);
    push_acc(1'b0, 3'd3, 8'h00, 0, 8'h80, 1'b0);
    push_acc(1'b0, 3'd5, 8'h00, 0, rx, 1'b0);
    push_done(idx, rx, er);
  endtask

  task automatic push_cfg(input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] b,
                          input logic br_err);
    push_acc(1'b1, 3'd0, c1, 0, 8'h00, 1'b0);
    push_acc(1'b1, 3'd1, c2, 0, 8'h00, 1'b0);
    push_acc(1'b1, 3'd2, b, 0, 8'h00, br_err);
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge PCLK);
      lat++;
    end while (done == '0 && lat < 400);
    check({tag, "_done_seen"}, 32'(lat < 400), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_acc.size() != 0 || exp_dn.size() != 0 || busy) && n < 400) begin
      @(negedge PCLK);
      n++;
    end
    check({tag, "_drained"}, 32'(n < 400), 32'd1);
  endtask

  // APB slave model plus access/done scoreboard monitor
  initial begin
    int          wait_left;
    logic        prev_psel;
    logic [NR-1:0] prev_done;
    rsp_t        cur;
    acc_t        a;
    dn_t         e;
    PREADY = 1'b0; PRDATA = 8'h00; PSLVERR = 1'b0;
    wait_left = 0; prev_psel = 1'b0; prev_done = '0;
    cur.stall = 0; cur.rd = 8'h00; cur.se = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) begin
        check("setup_after_idle", 32'(prev_psel), 32'd0);
        check("busy_in_access", 32'(busy), 32'd1);
        if (rsp_q.size() != 0) cur = rsp_q.pop_front();
        else begin cur.stall = 0; cur.rd = 8'h00; cur.se = 1'b0; end
        wait_left = cur.stall;
        PREADY = 1'b0;
      end else if (PSEL && PENABLE) begin
        if (wait_left > 0) begin
          PREADY = 1'b0;
          wait_left--;
        end else begin
          PREADY = 1'b1; PRDATA = cur.rd; PSLVERR = cur.se;
          acc_count++;
          if (exp_acc.size() == 0) check("unexpected_access", 32'd1, 32'd0);
          else begin
            a = exp_acc.pop_front();
            check("acc_write", 32'(PWRITE), 32'(a.w));
            check("acc_addr", 32'(PADDR), 32'(a.a));
            if (a.w) check("acc_wdata", 32'(PWDATA), 32'(a.d));
          end
        end
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0;
      end
      if (done != '0) begin
        check("done_single_pulse", 32'(prev_done), 32'd0);
        check("done_onehot", 32'($onehot(done)), 32'd1);
        if (exp_dn.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else begin
          e = exp_dn.pop_front();
          check("done_idx", 32'(done), 32'd1 << e.idx);
          check("done_rx", 32'(rx_data), 32'(e.rx));
          check("done_err", 32'(err), 32'(e.er));
        end
      end
      prev_psel = PSEL;
      prev_done = done;
    end
  end

  initial begin
    int lat_base, lat_stall, lat, a0, n;
    PRESET = 1'b1; cfg_load = 1'b0; req = '0; req_data = '0;
    cfg_cr1 = 8'h54; cfg_cr2 = 8'h00; cfg_br = 8'h11;
    repeat (3) @(negedge PCLK);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", 32'(PWDATA), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // reset leaves config pending: CR1/CR2/BR written before anything else
    push_cfg(8'h54, 8'h00, 8'h11, 1'b0);
    PRESET = 1'b0;
    wait_drain("cfg0");

    // basic byte from requester 0
    req_data[7:0] = 8'hA5;
    push_xfer(8'hA5, 8'h3C, 0, 1'b0, 0, 1'b0);
    req = 2'b01;
    wait_done("basic", lat_base);
    req = '0;
    wait_drain("basic");

    // DR write stalled 4 cycles on requester 1
    req_data[15:8] = 8'h96;
    push_xfer(8'h96, 8'h4B, 1, 1'b0, 4, 1'b0);
    a0 = acc_count;
    req = 2'b10;
    wait_done("stall", lat_stall);
    req = '0;
    wait_drain("stall");
    check("stall_latency_delta", 32'(lat_stall - lat_base), 32'd4);
    check("stall_access_count", 32'(acc_count - a0), 32'd4);

    // both requesting: strict alternation 0,1,0,1
    req_data = {8'h22, 8'h11};
    push_xfer(8'h11, 8'h01, 0, 1'b0, 0, 1'b0);
    push_xfer(8'h22, 8'h02, 1, 1'b0, 0, 1'b0);
    push_xfer(8'h11, 8'h03, 0, 1'b0, 0, 1'b0);
    push_xfer(8'h22, 8'h04, 1, 1'b0, 0, 1'b0);
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_done("rr", lat);
    req = '0;
    wait_drain("rr");

    // PSLVERR on the first SR read
    req_data[7:0] = 8'h5A;
    push_xfer(8'h5A, 8'h77, 0, 1'b1, 0, 1'b1);
    req = 2'b01;
    wait_done("slverr", lat);
    req = '0;
    wait_drain("slverr");

    // cfg_load mid-transfer: byte finishes, then config (BR write errors)
    req_data[15:8] = 8'hC3;
    cfg_cr1 = 8'h12; cfg_cr2 = 8'h34; cfg_br = 8'h56;
    push_xfer(8'hC3, 8'h99, 1, 1'b0, 0, 1'b0);
    push_cfg(8'h12, 8'h34, 8'h56, 1'b1);
    req = 2'b10;
    repeat (3) @(negedge PCLK);
    cfg_load = 1'b1;
    @(negedge PCLK);
    cfg_load = 1'b0;
    wait_done("cfg_busy", lat);
    req = '0;
    wait_drain("cfg_busy");

    // config error surfaces on the next done
    req_data[7:0] = 8'hE1;
    push_xfer(8'hE1, 8'h55, 0, 1'b0, 0, 1'b1);
    req = 2'b01;
    wait_done("cfg_err", lat);
    req = '0;
    wait_drain("cfg_err");

    // reset in the middle of a stalled DR write
    req_data[15:8] = 8'h3F;
    push_acc(1'b1, 3'd5, 8'h3F, 6, 8'h00, 1'b0);
    req = 2'b10;
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(PSEL && PENABLE) && n < 50);
    check("mid_access_reached", 32'(n < 50), 32'd1);
    PRESET = 1'b1;
    req = '0;
    exp_acc.delete(); rsp_q.delete(); exp_dn.delete();
    @(negedge PCLK);
    check("mid_rst_psel", 32'(PSEL), 32'd0);
    check("mid_rst_penable", 32'(PENABLE), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    push_cfg(8'h12, 8'h34, 8'h56, 1'b0);
    PRESET = 1'b0;
    wait_drain("post_rst");

`ifdef SEQ_TIMEOUT_EN
    // SR stuck at zero: POLL_LIMIT reads then a timed-out done
    req_data[7:0] = 8'h0F;
    push_acc(1'b1, 3'd5, 8'h0F, 0, 8'h00, 1'b0);
    for (int i = 0; i < PL; i++) push_acc(1'b0, 3'd3, 8'h00, 0, 8'h00, 1'b0);
    push_done(0, 8'h00, 1'b1);
    a0 = acc_count;
    req = 2'b01;
    wait_done("timeout", lat);
    req = '0;
    wait_drain("timeout");
    check("timeout_access_count", 32'(acc_count - a0), 32'(PL + 1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
